alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequential front-end that feeds the team's 16-bit combinational 8-opcode ALU and collects its result.
- Buffers incoming operations in a small FIFO and drives registered opcode/A/B to the ALU.
- Captures the ALU Result into a registered output slot with a valid/ready handshake.
- Optional chain mode replaces operand A with the previous result, so multi-step arithmetic runs without host round-trips.

Parameters:
- WIDTH, 16, operand/result width
- OPW, 3, opcode width
- DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  FIFO can accept
- in_opcode  in  OPW  operation code
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_chain  in  1  use last result as A
- alu_opcode  out  OPW  registered opcode to ALU
- alu_a  out  WIDTH  registered A to ALU
- alu_b  out  WIDTH  registered B to ALU
- alu_result  in  WIDTH  combinational ALU Result
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  captured result
- out_opcode  out  OPW  opcode that produced out_result
- busy  out  1  FIFO non-empty or operand stage valid

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: FIFO pointers and count = 0; state = IDLE; alu_opcode/alu_a/alu_b = 0; out_valid = 0; out_result = 0; out_opcode = 0; last_result = 0. Reset asserted mid-operation discards all queued and in-flight operations.
- Push: on in_valid && in_ready. in_ready = (count < DEPTH), independent of same-cycle pop, so a full FIFO never accepts. Pointers wrap modulo DEPTH. Each entry stores {chain, opcode, a, b}.
- slot_free = !out_valid || out_ready.
- FSM states:
  - IDLE: operand stage empty. If FIFO non-empty, pop head into the alu_* registers and go to EXEC.
  - EXEC: operand stage valid, ALU output settles this cycle.
    - If slot_free: capture alu_result into out_result, alu_opcode into out_opcode, alu_result into last_result; set out_valid = 1.
    - In the same edge, if FIFO is non-empty, pop the next entry and stay in EXEC; otherwise go to IDLE.
    - If not slot_free: go to STALL and hold the operand registers.
  - STALL: operand registers held. When slot_free, capture/pop exactly as in EXEC.
- Chain substitution at pop: A = last_result when the entry's chain bit = 1. If the pop coincides with a capture, forward the alu_result being captured instead. Chain to an empty history uses last_result (0 after reset).
- out_valid clears on out_valid && out_ready with no same-cycle capture. Capture while out_ready = 1 overwrites the slot; no bubble.
- Latency: accept edge k, operand registers load at k+1, out_valid high after k+2.
- Throughput: one operation per cycle when unstalled.
- Simultaneous push and pop: both occur; count unchanged.
- Arithmetic: no width change; alu_result is taken as-is, WIDTH bits.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
- Macro: ALU_SEQ_OPCNT_EN.
- Defined: adds output op_count (WIDTH bits), reset 0, incremented on every capture, wraps from 0xFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package alu_seq_pkg holds:
  - WIDTH and OPW defaults
  - state enum {IDLE, EXEC, STALL}
  - FIFO entry struct {chain, opcode, a, b}
- Natural sub-module: alu_seq_fifo, a parameterised synchronous FIFO with push/pop/count/full/empty. The FSM, operand stage and result slot stay in the top module.

Test Plan:
- Bench stub ALU for all scenarios: opcode 0 = A+B, opcode 1 = A-B.
- Single op: push {op0, A=100, B=23}, out_ready = 1 -> out_valid rises 2 cycles after accept; out_result = 123, out_opcode = 0; busy falls after capture.
- Chain: push {op0, 5, 7}, then {op1, chain=1, B=2} back-to-back -> results 12 then 10, on consecutive cycles (forwarding path).
- Backpressure: out_ready = 0, push 6 ops -> in_ready drops after 4 FIFO entries plus 1 operand and 1 slot are held. Release out_ready -> 6 results in order, one per cycle, none lost or duplicated.
- Full boundary: FIFO full with in_valid = 1 and a same-cycle pop -> no push that cycle; push accepted next cycle; pointer wrap verified over 10 ops.
- Reset mid-operation: assert rst_n = 0 with 3 queued and out_valid = 1 -> out_valid = 0, busy = 0 and in_ready = 1 immediately. A subsequent chain op uses A = 0.
- Optional: with ALU_SEQ_OPCNT_EN defined, 5 captures -> op_count = 5.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: default widths, FSM state set
// and the layout of one queued operation.
package alu_seq_pkg;

    localparam int ALU_SEQ_WIDTH = 16;
    localparam int ALU_SEQ_OPW   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2
    } alu_seq_state_e;

    typedef struct packed {
        logic                     chain;
        logic [ALU_SEQ_OPW-1:0]   opcode;
        logic [ALU_SEQ_WIDTH-1:0] a;
        logic [ALU_SEQ_WIDTH-1:0] b;
    } alu_seq_entry_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Host, ALU and result-consumer signals of alu_op_sequencer.
// op_count is present only when ALU_SEQ_OPCNT_EN is defined.
interface alu_op_sequencer_if import alu_seq_pkg::*; #(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int OPW   = ALU_SEQ_OPW
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_chain;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OPW-1:0]   out_opcode;
    logic             busy;
`ifdef ALU_SEQ_OPCNT_EN
    logic [WIDTH-1:0] op_count;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_chain, alu_result, out_ready,
        output in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode, busy,
        output op_count
    );
    modport master (
        output in_valid, in_opcode, in_a, in_b, in_chain, alu_result, out_ready,
        input  in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode, busy,
        input  op_count
    );
`else
    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_chain, alu_result, out_ready,
        output in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode, busy
    );
    modport master (
        output in_valid, in_opcode, in_a, in_b, in_chain, alu_result, out_ready,
        input  in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_opcode, busy
    );
`endif

endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO of queued ALU operations; head is visible combinationally
// so the consumer can pop and use it on the same edge.
module alu_seq_fifo import alu_seq_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  alu_seq_entry_t din,
    output alu_seq_entry_t head,
    output logic [AW:0]    count,
    output logic           full,
    output logic           empty
);
    alu_seq_entry_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues operations, drives registered operands to an external combinational ALU
// and captures its result into a valid/ready slot. Optional ALU_SEQ_OPCNT_EN adds op_count.
module alu_op_sequencer import alu_seq_pkg::*; #(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int OPW   = ALU_SEQ_OPW,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_EXEC  = EXEC;
    localparam logic [1:0] ST_STALL = STALL;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    alu_seq_entry_t   push_entry;
    alu_seq_entry_t   head;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             slot_free;
    logic             capture;
    logic [WIDTH-1:0] last_result;
    logic [WIDTH-1:0] next_a;

    assign push_entry = '{chain: bus.in_chain, opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b};
    assign bus.in_ready = !full;
    assign push      = bus.in_valid && !full;
    assign slot_free = !bus.out_valid || bus.out_ready;
    assign capture   = (state != ST_IDLE) && slot_free;
    assign pop       = !empty && ((state == ST_IDLE) || capture);
    assign bus.busy  = (count != '0) || (state != ST_IDLE);

    alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        next_a    = head.a;
        // A chained pop that meets a capture forwards the result being captured.
        if (head.chain) next_a = capture ? bus.alu_result : last_result;
        unique case (state)
            ST_IDLE:           if (!empty) state_nxt = ST_EXEC;
            ST_EXEC, ST_STALL: state_nxt = capture ? (empty ? ST_IDLE : ST_EXEC) : ST_STALL;
            default:           state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bus.alu_opcode <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_opcode <= '0;
            last_result    <= '0;
        end else begin
            // NOTE: non-blocking assignments let capture read the operand
            // registers' old values while pop loads their new ones on the same edge.
            state <= state_nxt;
            if (pop) begin
                bus.alu_opcode <= head.opcode;
                bus.alu_a      <= next_a;
                bus.alu_b      <= head.b;
            end
            if (capture) begin
                bus.out_result <= bus.alu_result;
                bus.out_opcode <= bus.alu_opcode;
                last_result    <= bus.alu_result;
                bus.out_valid  <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       bus.op_count <= '0;
        else if (capture) bus.op_count <= bus.op_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: stub ALU, in-order result model
// with chaining, and directed plus randomized scenarios.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  op;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;
    int   acc_count = 0;
    logic [15:0] model_last = '0;
    exp_t exp_q[$];

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.WIDTH(16), .OPW(3), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);

    // Model: operations complete in acceptance order; a chained op uses the
    // result of the previously accepted op (0 after reset).
    task automatic scoreboard();
        exp_t        e;
        logic [15:0] a_eff;
        logic [15:0] r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) begin
                    hs_count++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_spurious got %0h want no result", bus.out_result);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.out_result !== e.res || bus.out_opcode !== e.op) begin
                            errors++;
                            $display("FAIL sb_result got %0h/op%0d want %0h/op%0d",
                                     bus.out_result, bus.out_opcode, e.res, e.op);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    a_eff = bus.in_chain ? model_last : bus.in_a;
                    r = alu_ref(bus.in_opcode, a_eff, bus.in_b);
                    model_last = r;
                    exp_q.push_back('{res: r, op: bus.in_opcode});
                    acc_count++;
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic ch);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b; bus.in_chain = ch;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout got in_ready=0 want 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while ((bus.busy || bus.out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain_timeout got busy=%b out_valid=%b want 0/0", bus.busy, bus.out_valid);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_lost got %0d pending want 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_opcode = 0; bus.in_a = 0; bus.in_b = 0; bus.in_chain = 0;
        bus.out_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags got %b want 001", {bus.out_valid, bus.busy, bus.in_ready});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.out_result, bus.out_opcode} !== '0) begin
            errors++;
            $display("FAIL reset_regs got %0h/%0h/%0h/%0h/%0h want all 0",
                     bus.alu_opcode, bus.alu_a, bus.alu_b, bus.out_result, bus.out_opcode);
        end
    endtask

    task automatic test_single();
        int lat;
        bus.out_ready = 1'b1;
        push_op(3'd0, 16'd100, 16'd23, 1'b0);
        wait_out_valid(lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL single_latency got %0d want 2", lat);
        end
        checks++;
        if (bus.out_result !== 16'd123 || bus.out_opcode !== 3'd0) begin
            errors++;
            $display("FAIL single_result got %0d/op%0d want 123/op0", bus.out_result, bus.out_opcode);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy got %b want 0", bus.busy);
        end
        drain();
    endtask

    task automatic test_chain();
        int lat;
        bus.out_ready = 1'b1;
        push_op(3'd0, 16'd5, 16'd7, 1'b0);
        push_op(3'd1, 16'($urandom), 16'd2, 1'b1);
        wait_out_valid(lat);
        checks++;
        if (bus.out_result !== 16'd12) begin
            errors++;
            $display("FAIL chain_first got %0d want 12", bus.out_result);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'd10) begin
            errors++;
            $display("FAIL chain_second got v=%b %0d want v=1 10", bus.out_valid, bus.out_result);
        end
        drain();
    endtask

    task automatic fill_six();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            push_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
    endtask

    task automatic test_back_pressure();
        int hs0;
        fill_six();
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b011) begin
            errors++;
            $display("FAIL bp_full got rdy/v/busy=%b want 011", {bus.in_ready, bus.out_valid, bus.busy});
        end
        hs0 = hs_count;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stream[%0d] got out_valid=%b want 1", i, bus.out_valid);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || hs_count - hs0 !== 6) begin
            errors++;
            $display("FAIL bp_count got v=%b n=%0d want v=0 n=6", bus.out_valid, hs_count - hs0);
        end
        drain();
    endtask

    task automatic test_full_boundary();
        int hs0 = hs_count;
        fill_six();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_opcode = 3'd0; bus.in_a = 16'h1234; bus.in_b = 16'h0101; bus.in_chain = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_no_push got rdy=%b v=%b want rdy=0 v=1", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_next_accept got in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            push_op(3'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
        drain();
        checks++;
        if (hs_count - hs0 !== 10) begin
            errors++;
            $display("FAIL full_wrap_count got %0d want 10", hs_count - hs0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_opcode = 3'($urandom_range(0, 7));
            bus.in_a      = 16'($urandom);
            bus.in_b      = 16'($urandom);
            bus.in_chain  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        drain();
        checks++;
        if (hs_count !== acc_count) begin
            errors++;
            $display("FAIL random_balance got %0d results want %0d", hs_count, acc_count);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_op(3'd0, 16'($urandom), 16'($urandom), 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got v=%b busy=%b want 1/1", bus.out_valid, bus.busy);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_last = '0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_flags got %b want 001", {bus.out_valid, bus.busy, bus.in_ready});
        end
`ifdef ALU_SEQ_OPCNT_EN
        checks++;
        if (bus.op_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_opcount got %0d want 0", bus.op_count);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push_op(3'd0, 16'd999, 16'd7, 1'b1);
        wait_out_valid(lat);
        checks++;
        if (bus.out_result !== 16'd7) begin
            errors++;
            $display("FAIL rstmid_chain got %0d want 7", bus.out_result);
        end
        drain();
    endtask

`ifdef ALU_SEQ_OPCNT_EN
    task automatic test_op_count();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            push_op(3'd1, 16'($urandom), 16'($urandom), 1'b0);
        drain();
        checks++;
        if (bus.op_count !== 16'd5) begin
            errors++;
            $display("FAIL op_count got %0d want 5", bus.op_count);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            scoreboard();
        join_none
        test_reset();
        test_single();
        test_chain();
        test_back_pressure();
        test_full_boundary();
        test_random();
        test_reset_mid();
`ifdef ALU_SEQ_OPCNT_EN
        test_op_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
